// File: rtl/lcd_nibble_receiver_pkg.sv
// Shared definitions for the character-LCD nibble receiver: receiver states,
// HD44780 command constants, DDRAM line-wrap points and address helpers.
package lcd_nibble_receiver_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } rx_state_t;

   localparam logic [7:0] CMD_CLEAR     = 8'h01;
   localparam logic [7:0] CMD_HOME      = 8'h02;
   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [3:0] NIB_INIT_4BIT = 4'h2;

   localparam logic [6:0] ADDR_LINE0_END   = 7'h27;
   localparam logic [6:0] ADDR_LINE1_START = 7'h40;
   localparam logic [6:0] ADDR_LINE1_END   = 7'h67;

   // Home is 0000_001x, so bit 0 is a don't-care.
   function automatic logic [6:0] cmd_next_addr(input logic [7:0] cmd,
                                                input logic [6:0] addr);
      if ((cmd & CMD_SET_DDRAM) != 8'h00)
         return cmd[6:0];
      if (cmd == CMD_CLEAR || (cmd & 8'hFE) == CMD_HOME)
         return 7'h00;
      return addr;
   endfunction

   function automatic logic [6:0] char_next_addr(input logic [6:0] addr);
      if (addr == ADDR_LINE0_END)
         return ADDR_LINE1_START;
      if (addr == ADDR_LINE1_END)
         return 7'h00;
      return addr + 7'd1;
   endfunction

endpackage

// File: rtl/lcd_nibble_receiver_if.sv
// Four-bit character-LCD bus as seen between a display controller and a
// receiving endpoint.
interface lcd_nibble_receiver_if;
   logic       lcd_sf_e;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [3:0] lcd_nib;

   modport master (output lcd_sf_e, lcd_e, lcd_rs, lcd_rw, lcd_nib);
   modport slave  (input  lcd_sf_e, lcd_e, lcd_rs, lcd_rw, lcd_nib);
endinterface

// File: rtl/lcd_nibble_receiver_edge_sync.sv
// Synchronises the asynchronous LCD bus into clk and flags falling edges of
// e taken while the module is selected (sf_e = 1).
module lcd_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sf_e,
   input  logic       e,
   input  logic       rs,
   input  logic       rw,
   input  logic [3:0] nib,
   output logic       strobe,
   output logic       strobe_rs,
   output logic       strobe_rw,
   output logic [3:0] strobe_nib
);

   // Bundle layout: [7] sf_e, [6] e, [5] rs, [4] rw, [3:0] nib
   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  bus_s;
   logic                        e_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         e_prev <= 1'b0;
      end else begin
         sync_q[0] <= {sf_e, e, rs, rw, nib};
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         e_prev <= sync_q[SYNC_STAGES-1][6];
      end
   end

   assign bus_s      = sync_q[SYNC_STAGES-1];
   assign strobe     = e_prev & ~bus_s[6] & bus_s[7];
   assign strobe_rs  = bus_s[5];
   assign strobe_rw  = bus_s[4];
   assign strobe_nib = bus_s[3:0];

endmodule

// File: rtl/lcd_nibble_receiver.sv
// Receive endpoint of the 4-bit LCD bus: follows the 4-bit init handshake,
// pairs nibbles into bytes, decodes command/character writes and tracks DDRAM.
//
// state  | meaning
// INIT   | waiting for the single-nibble 0x2 that switches to 4-bit mode
// HIGH   | 4-bit mode, expecting the upper nibble of a byte
// LOW    | upper nibble held, expecting the lower nibble before timeout
module lcd_nibble_receiver
   import lcd_nibble_receiver_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lcd_nibble_receiver_if.slave lcd,
   output logic                 four_bit_mode,
   output logic                 byte_valid,
   output logic [7:0]           byte_data,
   output logic                 byte_rs,
   output logic                 cmd_valid,
   output logic                 char_valid,
   output logic [6:0]           char_addr,
   output logic [6:0]           cur_addr,
   output logic                 sync_err,
   output logic                 read_seen
);

   localparam int               CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             strobe;
   logic             strobe_rs;
   logic             strobe_rw;
   logic [3:0]       strobe_nib;
   logic             wr_edge;
   logic [7:0]       asm_byte;

   rx_state_t        state;
   logic [3:0]       hi_nib;
   logic             hi_rs;
   logic [CNT_W-1:0] timeout_cnt;

   lcd_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .sf_e       (lcd.lcd_sf_e),
      .e          (lcd.lcd_e),
      .rs         (lcd.lcd_rs),
      .rw         (lcd.lcd_rw),
      .nib        (lcd.lcd_nib),
      .strobe     (strobe),
      .strobe_rs  (strobe_rs),
      .strobe_rw  (strobe_rw),
      .strobe_nib (strobe_nib)
   );

   // Reads are only reported; they never advance the nibble protocol.
   assign wr_edge  = strobe & ~strobe_rw;
   assign asm_byte = {hi_nib, strobe_nib};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_INIT;
         hi_nib        <= 4'h0;
         hi_rs         <= 1'b0;
         timeout_cnt   <= '0;
         four_bit_mode <= 1'b0;
         byte_valid    <= 1'b0;
         byte_data     <= 8'h00;
         byte_rs       <= 1'b0;
         cmd_valid     <= 1'b0;
         char_valid    <= 1'b0;
         char_addr     <= 7'h00;
         cur_addr      <= 7'h00;
         sync_err      <= 1'b0;
         read_seen     <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         cmd_valid  <= 1'b0;
         char_valid <= 1'b0;
         sync_err   <= 1'b0;
         read_seen  <= strobe & strobe_rw;

         case (state)
            ST_INIT: begin
               if (wr_edge && !strobe_rs && strobe_nib == NIB_INIT_4BIT) begin
                  four_bit_mode <= 1'b1;
                  state         <= ST_HIGH;
               end
            end

            ST_HIGH: begin
               if (wr_edge) begin
                  hi_nib      <= strobe_nib;
                  hi_rs       <= strobe_rs;
                  timeout_cnt <= '0;
                  state       <= ST_LOW;
               end
            end

            ST_LOW: begin
               // A completing edge beats a coincident timeout.
               if (wr_edge) begin
                  byte_valid <= 1'b1;
                  byte_data  <= asm_byte;
                  byte_rs    <= hi_rs;
                  state      <= ST_HIGH;
                  if (hi_rs) begin
                     char_valid <= 1'b1;
                     char_addr  <= cur_addr;
                     cur_addr   <= char_next_addr(cur_addr);
                  end else begin
                     cmd_valid <= 1'b1;
                     cur_addr  <= cmd_next_addr(asm_byte, cur_addr);
                  end
               end else if (timeout_cnt == CNT_TC) begin
                  sync_err    <= 1'b1;
                  timeout_cnt <= '0;
                  state       <= ST_HIGH;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end

            default: state <= ST_INIT;
         endcase
      end
   end

endmodule
